// File: rtl/tag_req_sched_if.sv
// Request/array bundle for tag_req_sched: lookup, refill and ECC-fix inputs,
// array read/write port, and the lookup response / fix counter outputs.
interface tag_req_sched_if #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned WAY_N = 4,
  parameter int unsigned TAG_W = 28
);
  logic             lkp_req_valid_i;
  logic [IDX_W-1:0] lkp_req_idx_i;
  logic             lkp_req_ready_o;

  logic             rfl_req_valid_i;
  logic [IDX_W-1:0] rfl_req_idx_i;
  logic [WAY_N-1:0] rfl_req_way_i;
  logic [TAG_W-1:0] rfl_req_tag_i;
  logic             rfl_req_ready_o;

  logic             ecc_err_valid_i;
  logic [WAY_N-1:0] ecc_err_way_i;
  logic [TAG_W-1:0] ecc_fix_tag_i;

  logic             rd_req_valid_o;
  logic [IDX_W-1:0] rd_req_idx_o;
  logic [WAY_N-1:0] rd_req_way_o;

  logic             wr_req_valid_o;
  logic [IDX_W-1:0] wr_req_idx_o;
  logic [WAY_N-1:0] wr_req_way_o;
  logic [TAG_W-1:0] wr_req_tag_o;

  logic             lkp_rsp_valid_o;
  logic [7:0]       ecc_fix_cnt_o;

  modport slave (
    input  lkp_req_valid_i, lkp_req_idx_i,
    output lkp_req_ready_o,
    input  rfl_req_valid_i, rfl_req_idx_i, rfl_req_way_i, rfl_req_tag_i,
    output rfl_req_ready_o,
    input  ecc_err_valid_i, ecc_err_way_i, ecc_fix_tag_i,
    output rd_req_valid_o, rd_req_idx_o, rd_req_way_o,
    output wr_req_valid_o, wr_req_idx_o, wr_req_way_o, wr_req_tag_o,
    output lkp_rsp_valid_o, ecc_fix_cnt_o
  );

  modport master (
    output lkp_req_valid_i, lkp_req_idx_i,
    input  lkp_req_ready_o,
    output rfl_req_valid_i, rfl_req_idx_i, rfl_req_way_i, rfl_req_tag_i,
    input  rfl_req_ready_o,
    output ecc_err_valid_i, ecc_err_way_i, ecc_fix_tag_i,
    input  rd_req_valid_o, rd_req_idx_o, rd_req_way_o,
    input  wr_req_valid_o, wr_req_idx_o, wr_req_way_o, wr_req_tag_o,
    input  lkp_rsp_valid_o, ecc_fix_cnt_o
  );
endinterface

// File: rtl/tag_req_sched.sv
// Tag array request scheduler: refill > lookup with anti-starvation, plus an
// ECC correction write-back slot when TAG_ECC_FIX_EN is defined.
module tag_req_sched #(
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned WAY_N      = 4,
  parameter int unsigned TAG_W      = 28,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst_n,
  tag_req_sched_if.slave  bus
);

  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  typedef enum logic [0:0] {IDLE = 1'b0, FIX = 1'b1} state_e;

  state_e           state_q, state_nxt;
  logic [SC_W-1:0]  starve_cnt_q;
  logic             lkp_rsp_valid_q;

  logic             starved;
  logic             err_blk;
  logic             lkp_ready, rfl_ready;
  logic             lkp_gnt, rfl_gnt;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic [WAY_N-1:0] rd_way;
  logic             wr_valid;
  logic [IDX_W-1:0] wr_idx;
  logic [WAY_N-1:0] wr_way;
  logic [TAG_W-1:0] wr_tag;

`ifdef TAG_ECC_FIX_EN
  logic [IDX_W-1:0] rsp_idx_q;
  logic [IDX_W-1:0] fix_idx_q;
  logic [WAY_N-1:0] fix_way_q;
  logic [TAG_W-1:0] fix_tag_q;
  logic [7:0]       fix_cnt_q;
`else
  logic             unused_ecc;
  assign unused_ecc = ^{bus.ecc_err_valid_i, bus.ecc_err_way_i, bus.ecc_fix_tag_i};
`endif

  assign starved = (starve_cnt_q == STARVE_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Arbitration, error block and array port drive; all quiet while in reset.
  always_comb begin
    state_nxt = state_q;
    err_blk   = 1'b0;
    lkp_ready = 1'b0;
    rfl_ready = 1'b0;
    lkp_gnt   = 1'b0;
    rfl_gnt   = 1'b0;
    rd_valid  = 1'b0;
    rd_idx    = '0;
    rd_way    = '0;
    wr_valid  = 1'b0;
    wr_idx    = '0;
    wr_way    = '0;
    wr_tag    = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
`ifdef TAG_ECC_FIX_EN
          err_blk = lkp_rsp_valid_q && bus.ecc_err_valid_i;
`endif
          if (err_blk) begin
            state_nxt = FIX;
          end else begin
            lkp_ready = starved || !bus.rfl_req_valid_i;
            rfl_ready = !(starved && bus.lkp_req_valid_i);
            lkp_gnt   = bus.lkp_req_valid_i && lkp_ready;
            rfl_gnt   = bus.rfl_req_valid_i && rfl_ready;
            if (lkp_gnt) begin
              rd_valid = 1'b1;
              rd_idx   = bus.lkp_req_idx_i;
              rd_way   = '1;
            end else if (rfl_gnt) begin
              wr_valid = 1'b1;
              wr_idx   = bus.rfl_req_idx_i;
              wr_way   = bus.rfl_req_way_i;
              wr_tag   = bus.rfl_req_tag_i;
            end
          end
        end
        FIX: begin
`ifdef TAG_ECC_FIX_EN
          wr_valid = 1'b1;
          wr_idx   = fix_idx_q;
          wr_way   = fix_way_q;
          wr_tag   = fix_tag_q;
`endif
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Starvation counter and lookup response pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q    <= '0;
      lkp_rsp_valid_q <= 1'b0;
    end else begin
      lkp_rsp_valid_q <= lkp_gnt;
      if (lkp_gnt)
        starve_cnt_q <= '0;
      else if (bus.lkp_req_valid_i && rfl_gnt && !starved)
        starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

`ifdef TAG_ECC_FIX_EN
  // Correction capture and saturating write-back count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_idx_q <= '0;
      fix_idx_q <= '0;
      fix_way_q <= '0;
      fix_tag_q <= '0;
      fix_cnt_q <= 8'd0;
    end else begin
      if (lkp_gnt) rsp_idx_q <= bus.lkp_req_idx_i;
      if (err_blk) begin
        fix_idx_q <= rsp_idx_q;
        fix_way_q <= bus.ecc_err_way_i;
        fix_tag_q <= bus.ecc_fix_tag_i;
      end
      if (state_q == FIX && fix_cnt_q != 8'hFF) fix_cnt_q <= fix_cnt_q + 8'd1;
    end
  end

  assign bus.ecc_fix_cnt_o = fix_cnt_q;
`else
  assign bus.ecc_fix_cnt_o = 8'd0;
`endif

  assign bus.lkp_req_ready_o = lkp_ready;
  assign bus.rfl_req_ready_o = rfl_ready;
  assign bus.rd_req_valid_o  = rd_valid;
  assign bus.rd_req_idx_o    = rd_idx;
  assign bus.rd_req_way_o    = rd_way;
  assign bus.wr_req_valid_o  = wr_valid;
  assign bus.wr_req_idx_o    = wr_idx;
  assign bus.wr_req_way_o    = wr_way;
  assign bus.wr_req_tag_o    = wr_tag;
  assign bus.lkp_rsp_valid_o = lkp_rsp_valid_q;

endmodule

// File: tb/tb_tag_req_sched.sv
// Scoreboard bench for tag_req_sched: expected array ops are queued by the
// stimulus, and a negedge monitor pops and compares every issued op.
module tb_tag_req_sched;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned WAY_N = 4;
  localparam int unsigned TAG_W = 28;
`ifdef TAG_ECC_FIX_EN
  localparam bit FIX_EN = 1'b1;
`else
  localparam bit FIX_EN = 1'b0;
`endif

  typedef struct packed {
    logic             is_wr;
    logic [IDX_W-1:0] idx;
    logic [WAY_N-1:0] way;
    logic [TAG_W-1:0] tag;
  } op_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  op_t  exp_q[$];

  tag_req_sched_if #(.IDX_W(IDX_W), .WAY_N(WAY_N), .TAG_W(TAG_W)) bus ();

  tag_req_sched #(.IDX_W(IDX_W), .WAY_N(WAY_N), .TAG_W(TAG_W), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t rd_op(input logic [IDX_W-1:0] idx);
    rd_op = '{is_wr: 1'b0, idx: idx, way: '1, tag: '0};
  endfunction

  function automatic op_t wr_op(input logic [IDX_W-1:0] idx, input logic [WAY_N-1:0] way,
                                input logic [TAG_W-1:0] tag);
    wr_op = '{is_wr: 1'b1, idx: idx, way: way, tag: tag};
  endfunction

  // Monitor: every array op the DUT presents must match the queue head.
  always @(negedge clk) begin
    op_t e;
    op_t g;
    if (bus.rd_req_valid_o || bus.wr_req_valid_o) begin
      check("rd_wr_excl", 64'(bus.rd_req_valid_o && bus.wr_req_valid_o), 64'd0);
      g.is_wr = bus.wr_req_valid_o;
      g.idx   = bus.wr_req_valid_o ? bus.wr_req_idx_o : bus.rd_req_idx_o;
      g.way   = bus.wr_req_valid_o ? bus.wr_req_way_o : bus.rd_req_way_o;
      g.tag   = bus.wr_req_valid_o ? bus.wr_req_tag_o : '0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_op got=%0h exp=none", g);
      end else begin
        e = exp_q.pop_front();
        check("array_op", 64'(g), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.lkp_req_valid_i = 1'b1;
    bus.lkp_req_idx_i   = 6'd5;
    bus.rfl_req_valid_i = 1'b0;
    bus.rfl_req_idx_i   = '0;
    bus.rfl_req_way_i   = '0;
    bus.rfl_req_tag_i   = '0;
    bus.ecc_err_valid_i = 1'b0;
    bus.ecc_err_way_i   = '0;
    bus.ecc_fix_tag_i   = '0;

    // Reset: everything quiet even with a lookup pending.
    @(negedge clk);
    check("rst_rd_valid", 64'(bus.rd_req_valid_o), 64'd0);
    check("rst_lkp_ready", 64'(bus.lkp_req_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(bus.lkp_rsp_valid_o), 64'd0);
    check("rst_fix_cnt", 64'(bus.ecc_fix_cnt_o), 64'd0);

    // Lookup idx 5 from reset release; response one cycle later.
    next_cyc();
    rst_n = 1'b1;
    exp_q.push_back(rd_op(6'd5));
    @(negedge clk);
    check("lkp5_ready", 64'(bus.lkp_req_ready_o), 64'd1);
    check("lkp5_rsp_early", 64'(bus.lkp_rsp_valid_o), 64'd0);
    next_cyc();
    bus.lkp_req_valid_i = 1'b0;
    @(negedge clk);
    check("lkp5_rsp", 64'(bus.lkp_rsp_valid_o), 64'd1);

    // ECC pulse with no response pending is ignored.
    next_cyc();
    bus.ecc_err_valid_i = 1'b1;
    bus.ecc_err_way_i   = 4'b0010;
    bus.ecc_fix_tag_i   = 28'h1111111;
    @(negedge clk);
    check("pulse_rsp", 64'(bus.lkp_rsp_valid_o), 64'd0);
    check("pulse_lkp_ready", 64'(bus.lkp_req_ready_o), 64'd1);
    check("pulse_rfl_ready", 64'(bus.rfl_req_ready_o), 64'd1);
    next_cyc();
    bus.ecc_err_valid_i = 1'b0;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    check("pulse_fix_cnt", 64'(bus.ecc_fix_cnt_o), 64'd0);

    // Refill and lookup both valid: R,R,R,R,L repeating.
    next_cyc();
    bus.lkp_req_valid_i = 1'b1;
    bus.lkp_req_idx_i   = 6'd7;
    bus.rfl_req_valid_i = 1'b1;
    bus.rfl_req_idx_i   = 6'd3;
    bus.rfl_req_way_i   = 4'b0001;
    bus.rfl_req_tag_i   = 28'h1234567;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) exp_q.push_back(rd_op(6'd7));
      else            exp_q.push_back(wr_op(6'd3, 4'b0001, 28'h1234567));
      @(negedge clk);
      check($sformatf("starve_lkp_ready_%0d", i), 64'(bus.lkp_req_ready_o), 64'(i % 5 == 4));
      check($sformatf("starve_rfl_ready_%0d", i), 64'(bus.rfl_req_ready_o), 64'(i % 5 != 4));
      check($sformatf("starve_rsp_%0d", i), 64'(bus.lkp_rsp_valid_o), 64'(i == 5));
      if (i < 9) next_cyc();
    end
    next_cyc();
    bus.lkp_req_valid_i = 1'b0;
    bus.rfl_req_valid_i = 1'b0;
    @(negedge clk);
    check("starve_last_rsp", 64'(bus.lkp_rsp_valid_o), 64'd1);

    // Reset dropped during the write-back cycle.
    next_cyc();
    bus.lkp_req_valid_i = 1'b1;
    bus.lkp_req_idx_i   = 6'h11;
    exp_q.push_back(rd_op(6'h11));
    @(negedge clk);
    next_cyc();
    bus.lkp_req_valid_i = 1'b0;
    bus.ecc_err_valid_i = 1'b1;
    bus.ecc_err_way_i   = 4'b0001;
    bus.ecc_fix_tag_i   = 28'h0000123;
    @(negedge clk);
    check("rstfix_lkp_ready", 64'(bus.lkp_req_ready_o), 64'(!FIX_EN));
    @(posedge clk);
    bus.ecc_err_valid_i = 1'b0;
    #1;
    check("rstfix_wr_valid", 64'(bus.wr_req_valid_o), 64'(FIX_EN));
    check("rstfix_wr_idx", 64'(bus.wr_req_idx_o), FIX_EN ? 64'h11 : 64'h0);
    rst_n = 1'b0;
    #1;
    check("rstfix_wr_drop", 64'(bus.wr_req_valid_o), 64'd0);
    check("rstfix_cnt_rst", 64'(bus.ecc_fix_cnt_o), 64'd0);
    @(negedge clk);
    next_cyc();
    rst_n = 1'b1;
    bus.lkp_req_valid_i = 1'b1;
    bus.lkp_req_idx_i   = 6'd1;
    exp_q.push_back(rd_op(6'd1));
    @(negedge clk);
    check("rstfix_idle_ready", 64'(bus.lkp_req_ready_o), 64'd1);
    check("rstfix_cnt", 64'(bus.ecc_fix_cnt_o), 64'd0);
    next_cyc();
    bus.lkp_req_valid_i = 1'b0;
    @(negedge clk);
    check("rstfix_rsp", 64'(bus.lkp_rsp_valid_o), 64'd1);

    // Correction on lookup idx 9; a refill arriving in the error cycle waits.
    next_cyc();
    bus.lkp_req_valid_i = 1'b1;
    bus.lkp_req_idx_i   = 6'd9;
    exp_q.push_back(rd_op(6'd9));
    @(negedge clk);
    next_cyc();
    bus.lkp_req_valid_i = 1'b0;
    bus.ecc_err_valid_i = 1'b1;
    bus.ecc_err_way_i   = 4'b0100;
    bus.ecc_fix_tag_i   = 28'h0ABCDEF;
    bus.rfl_req_valid_i = 1'b1;
    bus.rfl_req_idx_i   = 6'd2;
    bus.rfl_req_way_i   = 4'b1000;
    bus.rfl_req_tag_i   = 28'h0000042;
    if (!FIX_EN) exp_q.push_back(wr_op(6'd2, 4'b1000, 28'h0000042));
    @(negedge clk);
    check("err_rsp", 64'(bus.lkp_rsp_valid_o), 64'd1);
    check("err_lkp_ready", 64'(bus.lkp_req_ready_o), 64'd0);
    check("err_rfl_ready", 64'(bus.rfl_req_ready_o), 64'(!FIX_EN));
    next_cyc();
    bus.ecc_err_valid_i = 1'b0;
    bus.rfl_req_valid_i = FIX_EN;
    if (FIX_EN) exp_q.push_back(wr_op(6'd9, 4'b0100, 28'h0ABCDEF));
    @(negedge clk);
    check("fix_rfl_ready", 64'(bus.rfl_req_ready_o), 64'(!FIX_EN));
    check("fix_lkp_ready", 64'(bus.lkp_req_ready_o), 64'(!FIX_EN));
    check("fix_cnt_pre", 64'(bus.ecc_fix_cnt_o), 64'd0);
    next_cyc();
    if (FIX_EN) exp_q.push_back(wr_op(6'd2, 4'b1000, 28'h0000042));
    @(negedge clk);
    check("post_rfl_ready", 64'(bus.rfl_req_ready_o), 64'd1);
    check("fix_cnt_post", 64'(bus.ecc_fix_cnt_o), 64'(FIX_EN));
    next_cyc();
    bus.rfl_req_valid_i = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
